step_to_bcd_seq: RTL and testbench
==================================

Name: step_to_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter for the maze step counter and other binary counters that feed the 7-segment display driver. It replaces a per-cycle divide/modulo conversion with an iterative shift-add-3 (double-dabble) engine that:
- handles any binary width and any digit count, with no hardware dividers;
- uses a start/done handshake;
- saturates on overflow.
The output is a packed nibble-per-digit bus, digit 0 = least significant.

Parameters:
BIN_W, 16, width of binary input (1..32)
DIGITS, 4, number of BCD digits produced (1..8)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion of bin_in; sampled only in IDLE
bin_in  input  BIN_W  unsigned binary value to convert
busy  output  1  high while a conversion is in progress (SHIFT state)
done  output  1  one-cycle pulse when bcd_out/overflow update
bcd_out  output  4*DIGITS  BCD result, nibble k = digit k (10^k), held between conversions
overflow  output  1  result saturated; valid with done, held until next done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, overflow=0, bcd_out=0, internal shift/scratch/count regs=0. Release is synchronous to clk. A reset asserted mid-conversion aborts it; no done pulse is generated for the aborted request.
- States: IDLE, SHIFT, FINISH.
- IDLE, start=1:
  - latch bin_in into the shift register; clear the BCD scratch; load count=BIN_W.
  - compute sat = (bin_in > 10^DIGITS-1), comparison done at max(BIN_W, 4*DIGITS) bits.
  - go to SHIFT; busy=1 the next cycle.
- IDLE, start=0: remain in IDLE.
- SHIFT (one bit per cycle):
  - every scratch nibble >=5 gets +3;
  - then {scratch, shreg} shifts left by 1, MSB of shreg entering scratch bit 0;
  - count decrements. When count reaches 1 (last shift performed), go to FINISH.
- FINISH (1 cycle):
  - bcd_out <= sat ? all digits 9 : scratch;
  - overflow <= sat; done=1; busy=0; return to IDLE.
- Latency: start sampled at edge N -> done high during cycle N+BIN_W+1, bcd_out valid from the same edge. Throughput: one conversion per BIN_W+2 cycles. start may be asserted again in the cycle done is high (the FSM is in IDLE then).
- start while busy or in FINISH: ignored, not queued; bin_in is not re-sampled.
- Outputs are registered, with no combinational path from inputs. bcd_out and overflow change only on the done edge (or on reset).
- Scratch is 4*DIGITS bits. Bits shifted out of the top nibble are discarded; sat determines the reported value, never the scratch carry.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: on the done edge, every digit above digit 0 that is 0 and has only zero digits above it is written as 4'hF (display driver blank code). Digit 0 is never blanked. Not applied when sat=1 (all 9s).
- Undefined: leading zeros are output as 4'h0. No extra logic is synthesised.

Test Plan:
- BIN_W=16, DIGITS=4: reset, start with bin_in=0 -> after 17 cycles done=1, bcd_out=16'h0000, overflow=0.
- Same config: bin_in=1234 -> done exactly BIN_W+1 cycles after start, bcd_out=16'h1234, overflow=0. Then bin_in=9999 -> 16'h9999, overflow=0.
- Same config: bin_in=65535 -> bcd_out=16'h9999, overflow=1. Rebuild with DIGITS=5, bin_in=65535 -> bcd_out=20'h65535, overflow=0.
- Start 42, then pulse start with bin_in=7 while busy=1 -> single done, bcd_out=16'h0042. Start asserted in the done cycle -> second conversion accepted.
- Start 500, assert rst_n=0 at cycle 8 of SHIFT -> outputs 0 immediately (async), no done pulse. After release, start 500 -> bcd_out=16'h0500.
- LEADING_ZERO_BLANK_EN defined: bin_in=7 -> 16'hFFF7; bin_in=0 -> 16'hFFF0; bin_in=1005 -> 16'h1005; bin_in=70000 (BIN_W=17) -> 16'h9999, overflow=1.

Source files
------------

// File: rtl/step_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with start/done handshake and overflow saturation.
// Optional build macro: LEADING_ZERO_BLANK_EN (leading zero digits reported as 4'hF).
module step_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [1:0]            state_dbg
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CMP_W = (BIN_W > SCR_W) ? BIN_W : SCR_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [CMP_W-1:0] LIMIT     = CMP_W'(pow10_m1(DIGITS));
  localparam logic [SCR_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  // Handshake: start is only honoured in IDLE; done is a one-cycle pulse
  // that coincides with the bcd_out/overflow update, and the FSM is already
  // back in IDLE during that cycle so a new start is accepted there.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [BIN_W-1:0]   shreg, shreg_n;
  logic [SCR_W-1:0]   scratch, scratch_n, adj;
  logic [CNT_W-1:0]   count, count_n;
  logic               sat, sat_n;
  logic [SCR_W-1:0]   bcd_n;
  logic               ovf_n, done_n;

  function automatic logic [SCR_W-1:0] final_digits(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
        if (lead && (s[4*k +: 4] == 4'h0)) r[4*k +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      scratch  <= '0;
      count    <= '0;
      sat      <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      scratch  <= scratch_n;
      count    <= count_n;
      sat      <= sat_n;
      bcd_out  <= bcd_n;
      overflow <= ovf_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    scratch_n = scratch;
    count_n   = count;
    sat_n     = sat;
    bcd_n     = bcd_out;
    ovf_n     = overflow;
    done_n    = 1'b0;
    adj       = scratch;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_n   = bin_in;
          scratch_n = '0;
          count_n   = CNT_W'(BIN_W);
          sat_n     = CMP_W'(bin_in) > LIMIT;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
        // Carry out of the top nibble is dropped; sat decides the reported value.
        {scratch_n, shreg_n} = {adj, shreg} << 1;
        count_n = count - CNT_W'(1);
        if (count == CNT_W'(1)) state_n = FINISH;
      end
      FINISH: begin
        done_n  = 1'b1;
        ovf_n   = sat;
        bcd_n   = sat ? ALL_NINES : final_digits(scratch);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state == SHIFT);
  assign state_dbg = state;

endmodule

// File: tb/tb_step_to_bcd_seq.sv
// Directed + randomized bench for step_to_bcd_seq; decimal reference model built from % and / arithmetic.
module tb_step_to_bcd_seq;
  localparam int BIN_W  = 16;
  localparam int DIGITS = 4;
  localparam int OW     = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [BIN_W-1:0]  bin_in;
  logic              busy, done, overflow;
  logic [OW-1:0]     bcd_out;
  logic [1:0]        state_dbg;

  int tests = 0;
  int fails = 0;

  step_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic longint unsigned max_val();
    longint unsigned p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return p - 1;
  endfunction

  function automatic logic model_ovf(input longint unsigned v);
    return v > max_val();
  endfunction

  function automatic logic [OW-1:0] model_bcd(input longint unsigned v);
    logic [OW-1:0] r;
    longint unsigned x = v;
    if (v > max_val()) begin
      for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'h9;
      return r;
    end
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = DIGITS - 1; k > 0; k--) begin
      if (r[4*k +: 4] != 4'h0) break;
      r[4*k +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  // scoreboard
  logic [OW-1:0] exp_q[$];
  logic          exp_ovf_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: called #1 after a posedge; returns #1 after the sampling edge
  task automatic start_conv(input logic [BIN_W-1:0] v);
    bin_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 3 * BIN_W; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag);
    logic [OW-1:0] e;
    logic          eo;
    e  = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    check({tag, "_bcd"}, 64'(bcd_out), 64'(e));
    check({tag, "_ovf"}, 64'(overflow), 64'(eo));
  endtask

  task automatic convert(input string tag, input logic [BIN_W-1:0] v);
    int lat;
    exp_q.push_back(model_bcd(v));
    exp_ovf_q.push_back(model_ovf(v));
    start_conv(v);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(BIN_W + 1));
    check_result(tag);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [BIN_W-1:0] v;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd_out), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    convert("zero", 0);
    convert("v1234", 1234);
    convert("v9999", 9999);
    convert("v10000", 10000);
    convert("v65535", 65535);
    convert("v7", 7);
    convert("v1005", 1005);
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("bcd_held", 64'(bcd_out), 64'(model_bcd(1005)));

    // start while busy is ignored
    exp_q.push_back(model_bcd(42));
    exp_ovf_q.push_back(model_ovf(42));
    start_conv(42);
    repeat (3) @(posedge clk);
    #1 check("busy_mid", 64'(busy), 64'd1);
    start_conv(7);
    wait_done(lat);
    check("ign_lat", 64'(lat), 64'(BIN_W + 1 - 4));
    check_result("ign");
    pulses = 0;
    for (int c = 0; c < BIN_W + 4; c++) begin
      @(posedge clk);
      #1 if (done === 1'b1) pulses++;
    end
    check("ign_no_extra_done", 64'(pulses), 64'd0);

    // start in the done cycle is accepted
    exp_q.push_back(model_bcd(321));
    exp_ovf_q.push_back(model_ovf(321));
    start_conv(321);
    wait_done(lat);
    check_result("b2b_a");
    convert("b2b_b", 8765);

    // reset mid-conversion aborts without done
    start_conv(500);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_bcd", 64'(bcd_out), 64'd0);
    check("arst_ovf", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < BIN_W + 4; c++) begin
      @(posedge clk);
      #1 if (done === 1'b1) pulses++;
    end
    check("arst_no_done", 64'(pulses), 64'd0);
    check("arst_idle_bcd", 64'(bcd_out), 64'd0);
    convert("after_rst", 500);

    // randomized stimulus
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) v = BIN_W'($urandom_range(0, int'(max_val())));
      else            v = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
      convert($sformatf("rnd%0d", i), v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
